bcd_scan_display: RTL and testbench
===================================

# bcd_scan_display

Parametrised multi-digit successor to the single-digit BCD-to-7-segment path. Accepts an unsigned binary value through a load/busy handshake and converts it to DIGITS BCD digits with a sequential shift-add-3 (double-dabble) converter. It time-multiplexes the digits onto one shared, active-low seven-segment bus with per-digit active-low anodes. Leading-zero blanking and overflow indication are supported. It sits between the calculator datapath result register and the board display pins.

## Interface
- DIGITS, 8: number of display digits/anodes (1..8).
- BIN_W, 27: width of binary input; must satisfy 2^BIN_W > 10^DIGITS-1.
- REFRESH_DIV, 100000: clk cycles each digit stays lit (1 kHz/digit at 100 MHz); ≥2.
- LZ_BLANK, 1: 1 = blank leading zeros (digit 0 is never blanked).
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- bin_in  input  BIN_W  unsigned value to display, sampled on accepted load.
- load  input  1  request conversion of bin_in; accepted only when busy=0.
- busy  output  1  conversion in progress; load ignored while high.
- done  output  1  one-cycle pulse when new digits are committed to display.
- overflow  output  1  registered: last accepted bin_in > 10^DIGITS-1.
- Seg_a..Seg_g  output  1 each  active-low segment drives for the currently scanned digit.
- AN  output  DIGITS  active-low anode enables; exactly one low after reset release.

## Operation
- Load accept: load=1 and busy=0 on an edge, giving capture of bin_in, overflow compare against MAX_VAL = 10^DIGITS-1, busy←1, and a BIN_W-iteration counter cleared.
- Converter FSM states:
  - IDLE: wait for accept, then go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left 1. After BIN_W iterations go to COMMIT.
  - COMMIT: copy the BCD nibbles to the display register, pulse done, busy←0, return to IDLE.
- Overflow: conversion still runs, but the committed display shows "-" (segment g only) on every digit; overflow stays set until the next accepted load.
- Display register holds the last committed value. The display never shows intermediate conversion state.
- Scan: divider counts 0..REFRESH_DIV-1. On wrap, scan index advances 0→1→…→DIGITS-1→0. AN = ~(1<<index).
- Segment decode: BCD 0-9 uses standard 7448 glyphs, active-low. Nibbles 10-15 (not produced normally) decode to blank.
- Blanking: with LZ_BLANK=1, digit i>0 is blank when it and all higher digits are zero. Blanking does not apply when overflow=1.
- Load asserted during busy is dropped; it is not queued.

## Timing
- Reset values: busy=0, done=0, overflow=0, display register=0, scan index=0, divider=0, FSM=IDLE.
- Registered outputs Seg_*/AN at reset: all 1 (all segments and anodes off).
- First edge after reset deassertion: AN=~1 and digit 0 shows "0". All other digits are blank with LZ_BLANK=1, or show "0" otherwise.
- Latency: load accepted at edge N, busy=1 from N. Shifts occur on edges N+1..N+BIN_W. COMMIT is at edge N+BIN_W+1: done=1, busy=0, and display registers are updated. Seg_* reflect the new value at edge N+BIN_W+2.
- Back-to-back: load may be accepted on the edge after done (cycle N+BIN_W+2).
- Seg_*/AN change together on the same edge, so no glitch combination reaches the pins.
- Reset mid-conversion aborts the conversion, returns every register to its reset value, and never emits done.

## Structure
- Package disp_pkg holds:
  - segment glyph constants (SEG_BLANK, SEG_DASH, digit 0-9 table);
  - function seg_decode(nibble) returning active-low {a..g};
  - function max_val(DIGITS) computing 10^DIGITS-1.
- Sub-module bin_to_bcd_seq (params BIN_W, DIGITS; ports clk, reset, start, bin, busy, done, bcd[4*DIGITS]) contains the converter FSM.
- Top level holds the overflow flag, display register, refresh divider, scan index, blanking logic and output registers.

## Test plan
- Reset then idle: after reset release, AN=8'b11111110, {Seg_a..g}=7'b0000001 ("0"), busy=0. AN rotates every REFRESH_DIV cycles (run with REFRESH_DIV=4).
- Load 12345678: busy high for 28 cycles and done one cycle at N+28. Scanned digits 0..7 show 8,7,6,5,4,3,2,1.
- Load 42 with LZ_BLANK=1: digit0=2, digit1=4, digits 2-7 Seg=7'b1111111. With LZ_BLANK=0, digits 2-7 show "0".
- Load 100000000 (>99,999,999): overflow=1 and all digits are Seg=7'b1111110 ("-"). A following load of 5 clears overflow and shows 5.
- Load during busy: load 7, then load 9 three cycles later. The 9 is ignored, exactly one done occurs, and the display shows 7.
- Reset at cycle N+10 of a conversion: done never pulses, busy=0, and the display returns to "0".

Source files
------------

// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the multi-digit BCD scan display:
//   - active-low seven-segment glyph constants, packed {a,b,c,d,e,f,g}
//   - converter FSM state encoding
//   - seg_decode(nibble): BCD nibble -> active-low glyph (10..15 -> blank)
//   - max_val(digits):    largest value representable on `digits` digits
// -----------------------------------------------------------------------------
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // 7448 glyphs (6 and 9 without tails), index 0 is the rightmost element.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0001100,   // 9
    7'b0000000,   // 8
    7'b0001111,   // 7
    7'b1100000,   // 6
    7'b0100100,   // 5
    7'b1001100,   // 4
    7'b0000110,   // 3
    7'b0010010,   // 2
    7'b1001111,   // 1
    7'b0000001    // 0
  };

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [63:0] max_val(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential shift-add-3 (double-dabble) binary to BCD converter.
// One iteration per clock; BIN_W iterations followed by a one-cycle COMMIT.
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   start  in   begin conversion of bin (honoured only while idle)
//   bin    in   BIN_W-bit unsigned value
//   busy   out  high from the start edge until COMMIT completes
//   done   out  high during the COMMIT cycle; bcd is final while it is high
//   bcd    out  DIGITS packed BCD nibbles, digit 0 in bits [3:0]
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
  import disp_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int                CNT_W     = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(BIN_W - 1);

  conv_state_e             state_q, state_d;
  logic [BIN_W-1:0]        bin_q, bin_d;
  logic [4*DIGITS-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*DIGITS-1:0]     bcd_adj;

  // Pre-shift correction: any nibble >= 5 would exceed 9 after doubling.
  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    bcd_adj = add3(bcd_q);
    case (state_q)
      CONV_IDLE: begin
        if (start) begin
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        bcd_d = {bcd_adj[4*DIGITS-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = CONV_COMMIT;
        end
      end
      CONV_COMMIT: begin
        state_d = CONV_IDLE;
      end
      default: begin
        state_d = CONV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != CONV_IDLE);
  assign done = (state_q == CONV_COMMIT);
  assign bcd  = bcd_q;

endmodule

// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
// Converts a binary value to DIGITS BCD digits and scans them onto a shared
// active-low seven-segment bus with per-digit active-low anodes.
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   bin_in       in   BIN_W-bit unsigned value, captured on accepted load
//   load         in   conversion request, accepted only while busy=0
//   busy         out  conversion in progress
//   done         out  one-cycle pulse when new digits are committed
//   overflow     out  last accepted bin_in exceeded 10^DIGITS-1
//   Seg_a..Seg_g out  active-low segments for the scanned digit
//   AN           out  active-low anode enables, one-cold
// -----------------------------------------------------------------------------
module bcd_scan_display
  import disp_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int BIN_W       = 27,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BIN_W-1:0]   bin_in,
  input  logic               load,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               Seg_a,
  output logic               Seg_b,
  output logic               Seg_c,
  output logic               Seg_d,
  output logic               Seg_e,
  output logic               Seg_f,
  output logic               Seg_g,
  output logic [DIGITS-1:0]  AN
);

  localparam logic [63:0]       MAX_VAL  = max_val(DIGITS);
  localparam int                DIV_W    = $clog2(REFRESH_DIV);
  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  logic                  conv_busy;
  logic                  conv_done;
  logic [4*DIGITS-1:0]   conv_bcd;
  logic                  accept;

  logic                  ovf_q, ovf_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic                  disp_ovf_q, disp_ovf_d;
  logic                  done_q, done_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;

  logic [DIGITS-1:0]     blank;
  logic                  higher_nz;
  logic [3:0]            cur_nib;
  logic                  cur_blank;

  assign accept = load & ~conv_busy;

  bin_to_bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .bin   (bin_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Digit i>0 is a leading zero when it and every digit above it are zero.
  always_comb begin
    blank     = '0;
    higher_nz = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      higher_nz = higher_nz | (disp_q[4*i +: 4] != 4'd0);
      blank[i]  = (LZ_BLANK != 0) && !higher_nz;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    an_d      = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = disp_q[4*i +: 4];
        cur_blank = blank[i];
        an_d[i]   = 1'b0;
      end
    end
  end

  always_comb begin
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    disp_ovf_d = disp_ovf_q;
    done_d     = conv_done;
    div_d      = div_q + DIV_W'(1);
    idx_d      = idx_q;

    if (accept) begin
      ovf_d = 64'(bin_in) > MAX_VAL;
    end

    // The overflow flag travels with the committed digits so dashes only
    // appear once the matching conversion is on display.
    if (conv_done) begin
      disp_d     = conv_bcd;
      disp_ovf_d = ovf_q;
    end

    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (disp_ovf_q) begin
      seg_d = SEG_DASH;
    end else if (cur_blank) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_decode(cur_nib);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
      done_q     <= 1'b0;
      div_q      <= '0;
      idx_q      <= '0;
      seg_q      <= '1;
      an_q       <= '1;
    end else begin
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      disp_ovf_q <= disp_ovf_d;
      done_q     <= done_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign busy     = conv_busy;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign Seg_a    = seg_q[6];
  assign Seg_b    = seg_q[5];
  assign Seg_c    = seg_q[4];
  assign Seg_d    = seg_q[3];
  assign Seg_e    = seg_q[2];
  assign Seg_f    = seg_q[1];
  assign Seg_g    = seg_q[0];
  assign AN       = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_display
// Two instances (leading-zero blanking on and off) share all inputs.
// The driver pushes each load it expects to be accepted into a queue; a
// negedge monitor predicts busy/done/overflow from the queue head and the
// scanned glyphs from the committed value using decimal arithmetic.
// -----------------------------------------------------------------------------
module tb_bcd_scan_display;

  localparam int    DIGITS = 8;
  localparam int    BIN_W  = 27;
  localparam int    RDIV   = 4;
  localparam longint MAXV  = 99999999;

  logic              clk;
  logic              reset;
  logic              load;
  logic [BIN_W-1:0]  bin_in;

  logic              busy1, done1, ovf1;
  logic              sa1, sb1, sc1, sd1, se1, sf1, sg1;
  logic [DIGITS-1:0] an1;
  logic              busy0, done0, ovf0;
  logic              sa0, sb0, sc0, sd0, se0, sf0, sg0;
  logic [DIGITS-1:0] an0;

  bcd_scan_display #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_DIV(RDIV), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .reset(reset), .bin_in(bin_in), .load(load),
    .busy(busy1), .done(done1), .overflow(ovf1),
    .Seg_a(sa1), .Seg_b(sb1), .Seg_c(sc1), .Seg_d(sd1),
    .Seg_e(se1), .Seg_f(sf1), .Seg_g(sg1), .AN(an1)
  );

  bcd_scan_display #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_DIV(RDIV), .LZ_BLANK(0)
  ) dut_nolz (
    .clk(clk), .reset(reset), .bin_in(bin_in), .load(load),
    .busy(busy0), .done(done0), .overflow(ovf0),
    .Seg_a(sa0), .Seg_b(sb0), .Seg_c(sc0), .Seg_d(sd0),
    .Seg_e(se0), .Seg_f(sf0), .Seg_g(sg0), .AN(an0)
  );

  typedef struct {
    longint val;
    longint acc;
  } item_t;

  item_t  q[$];
  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  int     k     = 0;
  logic   rst_edge = 1'b1;
  longint cur_val  = 0;
  bit     cur_ovf  = 1'b0;
  bit     ovf_flag = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= reset;
    k        <= reset ? 0 : k + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b1100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0001100;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input longint val, input bit ovf,
                                         input int idx, input bit lz);
    longint p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (ovf) return 7'b1111110;
    if (lz && idx > 0 && val < p) return 7'b1111111;
    return glyph(int'((val / p) % 10));
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (cyc != 0) begin
      if (rst_edge) begin
        chk("reset_an",   64'(an1), 64'(8'hFF));
        chk("reset_seg",  64'({sa1, sb1, sc1, sd1, se1, sf1, sg1}), 64'(7'h7F));
        chk("reset_busy", 64'(busy1), 64'd0);
        chk("reset_done", 64'(done1), 64'd0);
        chk("reset_ovf",  64'(ovf1),  64'd0);
        q.delete();
        cur_val  = 0;
        cur_ovf  = 1'b0;
        ovf_flag = 1'b0;
      end else begin
        int         idx;
        logic [7:0] ea;
        bit         eb, ed;
        idx = int'(((k - 1) / RDIV) % DIGITS);
        ea  = ~(8'd1 << idx);
        chk("an_scan",      64'(an1), 64'(ea));
        chk("an_scan_nolz", 64'(an0), 64'(ea));
        chk("seg_lz",   64'({sa1, sb1, sc1, sd1, se1, sf1, sg1}),
            64'(exp_seg(cur_val, cur_ovf, idx, 1'b1)));
        chk("seg_nolz", 64'({sa0, sb0, sc0, sd0, se0, sf0, sg0}),
            64'(exp_seg(cur_val, cur_ovf, idx, 1'b0)));
        if (q.size() > 0 && cyc == q[0].acc) ovf_flag = (q[0].val > MAXV);
        eb = (q.size() > 0) && (cyc >= q[0].acc) && (cyc <= q[0].acc + BIN_W);
        ed = (q.size() > 0) && (cyc == q[0].acc + BIN_W + 1);
        chk("busy",      64'(busy1), 64'(eb));
        chk("done",      64'(done1), 64'(ed));
        chk("done_nolz", 64'(done0), 64'(ed));
        chk("overflow",  64'(ovf1),  64'(ovf_flag));
        if (ed) begin
          cur_val = q[0].val;
          cur_ovf = ovf_flag;
          void'(q.pop_front());
        end
      end
    end
  end

  // Driver helpers: all entered and left at negedge+1.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_load(input longint v, input bit expect_accept);
    item_t it;
    load   = 1'b1;
    bin_in = BIN_W'(v);
    if (expect_accept) begin
      it.val = v;
      it.acc = cyc + 1;
      q.push_back(it);
    end
    @(negedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) return;
      @(negedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL wait_idle: conversion still pending after 200 cycles, expected completion");
  endtask

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    idle(40);

    do_load(12345678, 1'b1); wait_idle(); idle(40);
    do_load(42, 1'b1);       wait_idle(); idle(40);
    do_load(100000000, 1'b1); wait_idle(); idle(40);
    do_load(99999999, 1'b1); wait_idle();
    do_load(5, 1'b1);        wait_idle(); idle(40);

    do_load(7, 1'b1); idle(2); do_load(9, 1'b0);
    wait_idle(); idle(40);

    do_load(777, 1'b1);
    idle(9);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(40);

    for (int n = 0; n < 20; n++) begin
      longint v;
      if ($urandom_range(3, 0) == 0) v = longint'($urandom_range(134217727, 100000000));
      else                           v = longint'($urandom_range(99999999, 0));
      do_load(v, 1'b1);
      if ($urandom_range(1, 0) == 1) begin
        idle(int'($urandom_range(20, 0)));
        do_load(longint'($urandom), 1'b0);
      end
      wait_idle();
      idle(int'($urandom_range(40, 0)));
    end

    do_load(0, 1'b1); wait_idle(); idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
